fnd_scan_ctrl: RTL and testbench
================================

FND_SCAN_CTRL -- requirements
Module: fnd_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 100_000, clk cycles per digit slot (1 kHz scan at 100 MHz); legal range SCAN_DIV >= GUARD+2.
REQ-002 Parameter GUARD, default 2_000, clk cycles all digits are off after each sel change (anti-ghosting); legal range GUARD >= 1.
REQ-003 Parameter BLINK_DIV, default 500, scan ticks per blink half-period; legal range BLINK_DIV >= 1.
REQ-004 clk  input  1  single system clock; all logic is on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  scan enable; when low, the display is dark and scanning is frozen.
REQ-007 blink_en  input  1  enables blink paging; when low, sel[2] is forced to 0.
REQ-008 blank_mask  input  4  bit i high forces digit i dark during its slot.
REQ-009 sel  output  3  registered select {blink_phase, digit_idx[1:0]} for the 8:1 BCD mux.
REQ-010 fnd_com  output  4  registered active-low digit commons; at most one bit is low.
REQ-011 scan_tick  output  1  registered one-cycle pulse coincident with each digit_idx advance.
REQ-012 blink_phase  output  1  registered current blink page; equals sel[2].

Function
REQ-013 FSM states SHALL be IDLE, GUARD and DRIVE.
REQ-014 IDLE: fnd_com=4'b1111, prescaler=0, guard counter=0; digit_idx and blink state are held; en=1 moves the FSM to GUARD on the next edge.
REQ-015 The prescaler SHALL count 0..SCAN_DIV-1 in GUARD and DRIVE, and SHALL wrap to 0 after SCAN_DIV-1.
REQ-016 At the edge where the prescaler equals SCAN_DIV-1, the block SHALL update digit_idx to (digit_idx+1) mod 4, update sel, set scan_tick=1 for exactly one cycle, set fnd_com=4'b1111, and enter GUARD with the guard counter cleared.
REQ-017 GUARD SHALL last exactly GUARD cycles with fnd_com=4'b1111, then move to DRIVE.
REQ-018 DRIVE: fnd_com SHALL be 4'b1111 if blank_mask[digit_idx]=1; otherwise it SHALL be ~(4'b0001 << digit_idx), registered so that a blank_mask change appears on the next edge.
REQ-019 The blink counter SHALL count scan ticks 0..BLINK_DIV-1 only while blink_en=1; on the tick that wraps it, blink_phase SHALL toggle on the same edge as the digit_idx advance.
REQ-020 blink_en=0 SHALL clear the blink counter and blink_phase on the next edge, independent of en.
REQ-021 en falling in any state SHALL move the FSM to IDLE on the next edge; the prescaler and guard counter SHALL clear and fnd_com SHALL be 4'b1111 from that edge; no scan_tick is emitted.
REQ-022 If en falls in the same cycle the prescaler reaches SCAN_DIV-1, en SHALL win: no advance and no scan_tick.
REQ-023 sel SHALL never change while any fnd_com bit is low; every sel change SHALL be followed by at least GUARD dark cycles.

Reset
REQ-024 rst=1 at an edge SHALL force state=IDLE, sel=3'b000, fnd_com=4'b1111, scan_tick=0, blink_phase=0, and all counters to 0.
REQ-025 rst SHALL override en, blink_en and every in-flight GUARD or DRIVE state.
REQ-026 The block SHALL produce no scan_tick pulse during reset or in the cycle reset is released.

Verification (SCAN_DIV=8, GUARD=2, BLINK_DIV=4)
REQ-027 Reset, then en=1 and blink_en=0 -> fnd_com=1111 for 2 cycles, then 1110 with sel=000; scan_tick pulses every 8 cycles; sel sequence is 001, 010, 011, 000; fnd_com shows 1101, 1011, 0111, 1110, each preceded by exactly 2 dark cycles.
REQ-028 blink_en=1 -> sel[2] toggles every 4 ticks (every 32 cycles), coincident with scan_tick; blink_en=0 -> sel[2]=0 on the next edge.
REQ-029 blank_mask=4'b0100 -> fnd_com stays 1111 for the whole digit-2 slot, while sel=x10 still appears and scan_tick timing is unchanged.
REQ-030 en dropped in DRIVE with digit_idx=2 -> fnd_com=1111 on the next edge with sel held at 010; en reasserted -> 2 dark cycles, then 1011; the next tick arrives 8 cycles after re-entry.
REQ-031 en dropped in the wrap cycle (prescaler=7) -> no scan_tick and sel unchanged.
REQ-032 rst pulsed mid-GUARD with sel=111 -> next edge gives sel=000, fnd_com=1111, blink_phase=0; a checker asserts onehot0(~fnd_com) and no sel change while any fnd_com bit is low, throughout all scenarios.

Source files
------------

// File: rtl/fnd_scan_ctrl.sv
// Multiplexed 4-digit seven-segment scan controller: rotates the active common,
// inserts dark guard cycles after every select change, and pages between two banks for blinking.
module fnd_scan_ctrl #(
  parameter int unsigned SCAN_DIV  = 100_000,
  parameter int unsigned GUARD     = 2_000,
  parameter int unsigned BLINK_DIV = 500
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       blink_en_i,
  input  logic [3:0] blank_mask_i,
  output logic [2:0] sel_o,
  output logic [3:0] fnd_com_o,
  output logic       scan_tick_o,
  output logic       blink_phase_o
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned GW = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] PrescLast = PW'(SCAN_DIV - 1);
  localparam logic [GW-1:0] GuardLast = GW'(GUARD - 1);
  localparam logic [BW-1:0] BlinkLast = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    StIdle,
    StGuard,
    StDrive
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [GW-1:0] guard_q, guard_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [1:0]    digit_q, digit_d;
  logic          blink_phase_q, blink_phase_d;
  logic [3:0]    fnd_com_q, fnd_com_d;
  logic          scan_tick_q, scan_tick_d;

  logic          wrap;
  logic          blink_drop;
  logic [3:0]    drive_pat;

  // en has priority over the wrap, so a falling en in the last prescaler cycle cancels the advance.
  assign wrap = en_i && (state_q != StIdle) && (presc_q == PrescLast);

  // Clearing the blink page moves sel[2]; it is handled like a digit change so a lit digit never
  // sees its select move underneath it.
  assign blink_drop = !blink_en_i && blink_phase_q;

  always_comb begin
    drive_pat = 4'b1111;
    if (!blank_mask_i[digit_q]) begin
      drive_pat = ~(4'b0001 << digit_q);
    end
  end

  always_comb begin
    state_d       = state_q;
    presc_d       = presc_q;
    guard_d       = guard_q;
    digit_d       = digit_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    fnd_com_d     = 4'b1111;
    scan_tick_d   = 1'b0;

    if (!en_i) begin
      state_d = StIdle;
      presc_d = '0;
      guard_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StGuard;
          presc_d = '0;
          guard_d = '0;
        end
        StGuard, StDrive: begin
          presc_d = wrap ? '0 : presc_q + PW'(1);
          if (wrap) begin
            digit_d     = digit_q + 2'd1;
            scan_tick_d = 1'b1;
            state_d     = StGuard;
            guard_d     = '0;
          end else if (blink_drop) begin
            state_d = StGuard;
            guard_d = '0;
          end else if (state_q == StGuard) begin
            if (guard_q == GuardLast) begin
              state_d   = StDrive;
              guard_d   = '0;
              fnd_com_d = drive_pat;
            end else begin
              guard_d = guard_q + GW'(1);
            end
          end else begin
            fnd_com_d = drive_pat;
          end
        end
        default: begin
          state_d = StIdle;
          presc_d = '0;
          guard_d = '0;
        end
      endcase
    end

    if (!blink_en_i) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (wrap) begin
      if (blink_cnt_q == BlinkLast) begin
        blink_cnt_d   = '0;
        blink_phase_d = !blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      presc_q       <= '0;
      guard_q       <= '0;
      digit_q       <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      fnd_com_q     <= 4'b1111;
      scan_tick_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      guard_q       <= guard_d;
      digit_q       <= digit_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      fnd_com_q     <= fnd_com_d;
      scan_tick_q   <= scan_tick_d;
    end
  end

  assign sel_o         = {blink_phase_q, digit_q};
  assign fnd_com_o     = fnd_com_q;
  assign scan_tick_o   = scan_tick_q;
  assign blink_phase_o = blink_phase_q;

  // Ghost-free invariants: at most one common active, and select moves only while dark.
  a_com_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(~fnd_com_q));
  a_sel_dark : assert property (@(posedge clk_i) disable iff (rst_i)
    (sel_o != $past(sel_o)) |-> (fnd_com_q == 4'b1111));

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboard bench for fnd_scan_ctrl: directed stimulus pushes expected per-tick results,
// a negedge monitor pops them on each scan_tick and also checks the ghosting invariants.
module tb_fnd_scan_ctrl;

  localparam int unsigned Guard = 2;

  logic       clk;
  logic       rst;
  logic       en;
  logic       blink_en;
  logic [3:0] blank_mask;
  logic [2:0] sel;
  logic [3:0] fnd_com;
  logic       scan_tick;
  logic       blink_phase;

  fnd_scan_ctrl #(
    .SCAN_DIV (8),
    .GUARD    (Guard),
    .BLINK_DIV(4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .en_i         (en),
    .blink_en_i   (blink_en),
    .blank_mask_i (blank_mask),
    .sel_o        (sel),
    .fnd_com_o    (fnd_com),
    .scan_tick_o  (scan_tick),
    .blink_phase_o(blink_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] sel;
    logic [3:0] fnd;
    logic [7:0] gap;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input bit ok, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push(input logic [2:0] s, input logic [3:0] f, input logic [7:0] g);
    exp_t e;
    e.sel = s;
    e.fnd = f;
    e.gap = g;
    sb_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor state
  exp_t       cur;
  bit         pend      = 1'b0;
  int         off       = 0;
  int         cyc       = 0;
  int         last_tick = 0;
  bit         have_last = 1'b0;
  bit         mon_live  = 1'b0;
  logic [2:0] prev_sel  = 3'b000;
  bit         sel_armed = 1'b0;
  int         dark_run  = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      pend      = 1'b0;
      have_last = 1'b0;
      sel_armed = 1'b0;
    end else begin
      mon_live = 1'b1;
      if (scan_tick) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_tick", 1'b0, {29'd0, sel}, 0);
        end else begin
          cur = sb_q.pop_front();
          chk("tick_sel", sel === cur.sel, {29'd0, sel}, {29'd0, cur.sel});
          chk("tick_phase", blink_phase === cur.sel[2], {31'd0, blink_phase},
              {31'd0, cur.sel[2]});
          if (cur.gap != 0 && have_last)
            chk("tick_gap", (cyc - last_tick) == int'(cur.gap), cyc - last_tick,
                {24'd0, cur.gap});
          pend = 1'b1;
          off  = 0;
        end
        last_tick = cyc;
        have_last = 1'b1;
      end
      if (pend) begin
        if (off < 2) begin
          chk("guard_dark", fnd_com === 4'b1111, {28'd0, fnd_com}, 32'hF);
        end else begin
          chk("slot_fnd", fnd_com === cur.fnd, {28'd0, fnd_com}, {28'd0, cur.fnd});
          pend = 1'b0;
        end
        off++;
      end
    end

    if (mon_live && !rst) begin
      chk("onehot0_com", $onehot0(~fnd_com), {28'd0, fnd_com}, 0);
      if (sel !== prev_sel) begin
        chk("sel_change_dark", fnd_com === 4'b1111, {28'd0, fnd_com}, 32'hF);
        sel_armed = 1'b1;
        dark_run  = 1;
      end else if (sel_armed) begin
        if (fnd_com === 4'b1111) begin
          dark_run++;
        end else begin
          chk("guard_len", dark_run >= int'(Guard), dark_run, Guard);
          sel_armed = 1'b0;
        end
      end
    end
    prev_sel = sel;
  end

  task automatic drain(input int max_cyc, input string name);
    int n = 0;
    while ((sb_q.size() != 0 || pend) && n < max_cyc) begin
      step(1);
      n++;
    end
    chk(name, (sb_q.size() == 0) && !pend, sb_q.size(), 0);
  endtask

  task automatic wait_sel(input logic [2:0] s, input int max_cyc, input string name);
    int n = 0;
    while (sel !== s && n < max_cyc) begin
      step(1);
      n++;
    end
    chk(name, sel === s, {29'd0, sel}, {29'd0, s});
  endtask

  initial begin
    int lat;
    int dark;
    int n;

    // Reset overrides en and blink_en
    rst        = 1'b1;
    en         = 1'b1;
    blink_en   = 1'b1;
    blank_mask = 4'b0000;
    step(3);
    chk("rst_sel", sel === 3'b000, {29'd0, sel}, 0);
    chk("rst_fnd", fnd_com === 4'b1111, {28'd0, fnd_com}, 32'hF);
    chk("rst_tick", scan_tick === 1'b0, {31'd0, scan_tick}, 0);
    chk("rst_phase", blink_phase === 1'b0, {31'd0, blink_phase}, 0);
    rst      = 1'b0;
    en       = 1'b0;
    blink_en = 1'b0;
    step(2);
    chk("idle_fnd", fnd_com === 4'b1111, {28'd0, fnd_com}, 32'hF);
    chk("idle_tick", scan_tick === 1'b0, {31'd0, scan_tick}, 0);

    // Basic scan, no blink
    en = 1'b1;
    push(3'b001, 4'b1101, 8);
    push(3'b010, 4'b1011, 8);
    push(3'b011, 4'b0111, 8);
    push(3'b000, 4'b1110, 8);
    step(1);
    chk("entry_dark0", fnd_com === 4'b1111, {28'd0, fnd_com}, 32'hF);
    step(1);
    chk("entry_dark1", fnd_com === 4'b1111, {28'd0, fnd_com}, 32'hF);
    step(1);
    chk("entry_lit", fnd_com === 4'b1110, {28'd0, fnd_com}, 32'hE);
    chk("entry_sel", sel === 3'b000, {29'd0, sel}, 0);
    drain(60, "drain_basic");

    // Blink paging, then drop blink_en while on the upper page
    blink_en = 1'b1;
    push(3'b001, 4'b1101, 8);
    push(3'b010, 4'b1011, 8);
    push(3'b011, 4'b0111, 8);
    push(3'b100, 4'b1110, 8);
    push(3'b101, 4'b1101, 8);
    drain(60, "drain_blink");
    blink_en = 1'b0;
    step(1);
    chk("bdrop_sel", sel === 3'b001, {29'd0, sel}, 1);
    chk("bdrop_phase", blink_phase === 1'b0, {31'd0, blink_phase}, 0);
    chk("bdrop_dark0", fnd_com === 4'b1111, {28'd0, fnd_com}, 32'hF);
    step(1);
    chk("bdrop_dark1", fnd_com === 4'b1111, {28'd0, fnd_com}, 32'hF);
    step(1);
    chk("bdrop_lit", fnd_com === 4'b1101, {28'd0, fnd_com}, 32'hD);
    push(3'b010, 4'b1011, 8);
    push(3'b011, 4'b0111, 8);
    push(3'b000, 4'b1110, 8);
    drain(40, "drain_bdrop");

    // Blank digit 2
    blank_mask = 4'b0100;
    push(3'b001, 4'b1101, 8);
    push(3'b010, 4'b1111, 8);
    push(3'b011, 4'b0111, 8);
    wait_sel(3'b010, 30, "blank_reach_sel");
    dark = 0;
    for (int k = 0; k < 7; k++) begin
      if (fnd_com === 4'b1111) dark++;
      step(1);
    end
    chk("blank_slot_dark", dark == 7, dark, 7);
    drain(30, "drain_blank");
    blank_mask = 4'b0000;

    // en drop in DRIVE on digit 2, then re-entry
    push(3'b000, 4'b1110, 8);
    push(3'b001, 4'b1101, 8);
    push(3'b010, 4'b1011, 8);
    drain(40, "drain_pre_drop");
    en = 1'b0;
    step(1);
    chk("endrop_fnd", fnd_com === 4'b1111, {28'd0, fnd_com}, 32'hF);
    chk("endrop_sel", sel === 3'b010, {29'd0, sel}, 2);
    chk("endrop_tick", scan_tick === 1'b0, {31'd0, scan_tick}, 0);
    step(3);
    chk("endrop_hold_sel", sel === 3'b010, {29'd0, sel}, 2);
    en = 1'b1;
    push(3'b011, 4'b0111, 0);
    step(1);
    lat = 0;
    chk("reentry_dark0", fnd_com === 4'b1111, {28'd0, fnd_com}, 32'hF);
    step(1);
    lat++;
    chk("reentry_dark1", fnd_com === 4'b1111, {28'd0, fnd_com}, 32'hF);
    step(1);
    lat++;
    chk("reentry_lit", fnd_com === 4'b1011, {28'd0, fnd_com}, 32'hB);
    while (scan_tick !== 1'b1 && lat < 20) begin
      step(1);
      lat++;
    end
    chk("reentry_tick_latency", lat == 8, lat, 8);

    // en drop in the wrap cycle
    step(7);
    en = 1'b0;
    step(1);
    chk("wrapdrop_tick", scan_tick === 1'b0, {31'd0, scan_tick}, 0);
    chk("wrapdrop_sel", sel === 3'b011, {29'd0, sel}, 3);
    chk("wrapdrop_fnd", fnd_com === 4'b1111, {28'd0, fnd_com}, 32'hF);
    step(2);
    chk("wrapdrop_hold_sel", sel === 3'b011, {29'd0, sel}, 3);

    // Reach sel=111 and reset mid-GUARD
    blink_en = 1'b1;
    en       = 1'b1;
    push(3'b000, 4'b1110, 0);
    push(3'b001, 4'b1101, 8);
    push(3'b010, 4'b1011, 8);
    push(3'b111, 4'b0111, 8);
    n = 0;
    while (sb_q.size() != 0 && n < 60) begin
      step(1);
      n++;
    end
    chk("reach_111", sb_q.size() == 0, sb_q.size(), 0);
    chk("pre_rst_sel", sel === 3'b111, {29'd0, sel}, 7);
    chk("pre_rst_dark", fnd_com === 4'b1111, {28'd0, fnd_com}, 32'hF);
    rst = 1'b1;
    step(1);
    chk("midrst_sel", sel === 3'b000, {29'd0, sel}, 0);
    chk("midrst_fnd", fnd_com === 4'b1111, {28'd0, fnd_com}, 32'hF);
    chk("midrst_phase", blink_phase === 1'b0, {31'd0, blink_phase}, 0);
    chk("midrst_tick", scan_tick === 1'b0, {31'd0, scan_tick}, 0);
    step(1);
    chk("midrst_tick2", scan_tick === 1'b0, {31'd0, scan_tick}, 0);
    rst = 1'b0;
    push(3'b001, 4'b1101, 0);
    step(1);
    chk("release_tick", scan_tick === 1'b0, {31'd0, scan_tick}, 0);
    chk("release_fnd", fnd_com === 4'b1111, {28'd0, fnd_com}, 32'hF);
    drain(30, "drain_post_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
